// File: rtl/ft245_fifo_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// ft245_fifo_if : FT245 USB FIFO pin bridge (read strobes, buffered writes)
// Revision 1.0
// ============================================================================
module ft245_fifo_if #(
    parameter int RD_LOW_CYC   = 3,
    parameter int WR_SETUP_CYC = 1,
    parameter int WR_LOW_CYC   = 2,
    parameter int RECOV_CYC    = 3,
    parameter int TX_AW        = 4
) (
    input  logic       clk,
    input  logic       _reset,
    input  logic       _ft_rxf,
    input  logic       _ft_txe,
    input  logic [7:0] ft_data_in,
    output logic [7:0] ft_data_out,
    output logic       ft_data_oe,
    output logic       _ft_rd,
    output logic       _ft_wr,
    input  logic       rx_ready,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    input  logic [7:0] tx_byte,
    input  logic       tx_wr,
    output logic       tx_full,
    output logic       tx_empty,
    output logic       tx_ovf
);

    localparam int DEPTH = 1 << TX_AW;
    localparam int CW    = TX_AW + 1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_LOW   = 3'd1,
        S_WR_SETUP = 3'd2,
        S_WR_LOW   = 3'd3,
        S_RECOV    = 3'd4
    } state_t;

    state_t          r_state;
    logic [7:0]      r_cnt;
    logic            r_last_rd;
    logic [1:0]      r_rxf_sync;
    logic [1:0]      r_txe_sync;
    logic [7:0]      r_mem [DEPTH];
    logic [TX_AW-1:0] r_wr_ptr;
    logic [TX_AW-1:0] r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   w_count_nxt;
    logic            w_rd_req;
    logic            w_wr_req;
    logic            w_pop;
    logic            w_push;

    // Plain two-flop synchronisers; the FT flags are asynchronous to clk.
    always_ff @(posedge clk) begin
        r_rxf_sync <= {r_rxf_sync[0], _ft_rxf};
        r_txe_sync <= {r_txe_sync[0], _ft_txe};
    end

    assign w_rd_req = !r_rxf_sync[1] && rx_ready;
    assign w_wr_req = !r_txe_sync[1] && !tx_empty;
    assign w_pop    = (r_state == S_WR_LOW) && (r_cnt == 8'(WR_LOW_CYC - 1));
    assign w_push   = tx_wr && (!tx_full || w_pop);

    always_ff @(posedge clk) begin
        if (!_reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_last_rd   <= 1'b0;
            _ft_rd      <= 1'b1;
            _ft_wr      <= 1'b1;
            ft_data_oe  <= 1'b0;
            ft_data_out <= 8'h00;
            rx_byte     <= 8'h00;
            rx_valid    <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Round-robin when both sides are requesting.
                    if (w_rd_req && (!w_wr_req || !r_last_rd)) begin
                        _ft_rd  <= 1'b0;
                        r_cnt   <= 8'd0;
                        r_state <= S_RD_LOW;
                    end else if (w_wr_req) begin
                        ft_data_out <= r_mem[r_rd_ptr];
                        ft_data_oe  <= 1'b1;
                        r_cnt       <= 8'd0;
                        r_state     <= S_WR_SETUP;
                    end
                end
                S_RD_LOW: begin
                    if (r_cnt == 8'(RD_LOW_CYC - 1)) begin
                        rx_byte   <= ft_data_in;
                        rx_valid  <= 1'b1;
                        _ft_rd    <= 1'b1;
                        r_last_rd <= 1'b1;
                        r_cnt     <= 8'd0;
                        r_state   <= S_RECOV;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_WR_SETUP: begin
                    if (r_cnt == 8'(WR_SETUP_CYC - 1)) begin
                        _ft_wr  <= 1'b0;
                        r_cnt   <= 8'd0;
                        r_state <= S_WR_LOW;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_WR_LOW: begin
                    if (w_pop) begin
                        _ft_wr    <= 1'b1;
                        r_last_rd <= 1'b0;
                        r_cnt     <= 8'd0;
                        r_state   <= S_RECOV;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_RECOV: begin
                    // Bus stays driven one cycle past the write strobe for data hold.
                    if (r_cnt == 8'd0) ft_data_oe <= 1'b0;
                    if (r_cnt == 8'(RECOV_CYC - 1)) begin
                        r_cnt   <= 8'd0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= tx_byte;
    end

    always_ff @(posedge clk) begin
        if (!_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            tx_full  <= 1'b0;
            tx_empty <= 1'b1;
            tx_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (tx_wr && tx_full && !w_pop) tx_ovf <= 1'b1;
            r_count  <= w_count_nxt;
            tx_full  <= (w_count_nxt == CW'(DEPTH));
            tx_empty <= (w_count_nxt == '0);
        end
    end

endmodule
`default_nettype wire

// File: doc/ft245_fifo_if.md
Name: ft245_fifo_if

Overview:
Bridges the FT245-style USB FIFO chip pins to the serial command decoder. The block sits directly upstream of serial on the receive path and directly downstream of it on the transmit path.
- Receive: generates the _ft_rd strobe, samples host bytes and hands each to serial as a one-cycle rx_valid pulse.
- Transmit: buffers response bytes from serial in a small FIFO and drains them with correctly timed _ft_wr strobes.
- Owns the bidirectional data-bus turnaround (ft_data_oe).

Parameters:
RD_LOW_CYC, 3, cycles _ft_rd is held low; data is sampled on the edge that ends the low phase (min 2).
WR_SETUP_CYC, 1, cycles data is driven with _ft_wr high before _ft_wr falls (min 1).
WR_LOW_CYC, 2, cycles _ft_wr is held low (min 1).
RECOV_CYC, 3, idle cycles after any strobe rises before the next arbitration (min 3, covers 2-flop sync latency).
TX_AW, 4, transmit FIFO address width (depth 2^TX_AW = 16).

Ports:
clk  in  1  system clock
_reset  in  1  synchronous active-low reset
_ft_rxf  in  1  FT chip: low = host byte available (asynchronous)
_ft_txe  in  1  FT chip: low = room to accept a byte (asynchronous)
ft_data_in  in  8  data bus from pad
ft_data_out  out  8  data bus to pad
ft_data_oe  out  1  pad output enable, high = drive bus
_ft_rd  out  1  FT read strobe, active low
_ft_wr  out  1  FT write strobe, active low
rx_ready  in  1  serial can accept a byte
rx_byte  out  8  received byte, held until next read
rx_valid  out  1  one-cycle pulse, rx_byte valid
tx_byte  in  8  response byte from serial
tx_wr  in  1  push tx_byte into the transmit FIFO
tx_full  out  1  transmit FIFO full
tx_empty  out  1  transmit FIFO empty
tx_ovf  out  1  sticky: a push was dropped because the FIFO was full

Behaviour:
- Reset (sync, _reset=0 at an edge) values, applied even mid-transaction:
  - _ft_rd=1, _ft_wr=1, ft_data_oe=0, ft_data_out=0.
  - rx_byte=0, rx_valid=0.
  - FIFO emptied, so tx_empty=1, tx_full=0; tx_ovf=0.
  - State=IDLE, last_grant=WRITE.
- Synchronisation: _ft_rxf and _ft_txe each pass through 2 flops (rxf_s, txe_s); only the synced copies are used.
- States:
  - IDLE: evaluates two requests.
    - rd_req = !rxf_s & rx_ready.
    - wr_req = !txe_s & !tx_empty.
    - Only one request: grant it.
    - Both: grant the opposite of last_grant (round-robin).
    - Neither: stay in IDLE.
  - RD_LOW: entered with _ft_rd<=0; a counter runs RD_LOW_CYC cycles. On the exit edge:
    - rx_byte<=ft_data_in, rx_valid<=1, _ft_rd<=1, last_grant<=READ.
    - Go to RECOV.
  - WR_SETUP: entered with ft_data_out<=FIFO head, ft_data_oe<=1, _ft_wr=1; lasts WR_SETUP_CYC cycles, then _ft_wr<=0.
  - WR_LOW: lasts WR_LOW_CYC cycles. On the exit edge:
    - _ft_wr<=1, FIFO pop, last_grant<=WRITE.
    - Go to RECOV.
  - RECOV: lasts RECOV_CYC cycles.
    - ft_data_oe is held for the first cycle of RECOV (data hold) and cleared on the following edge.
    - Then go to IDLE.
- Strobe overlap: _ft_rd and _ft_wr are never low simultaneously, and ft_data_oe=0 whenever _ft_rd=0.
- rx_valid: exactly one cycle per read. rx_ready is sampled only in IDLE; dropping it mid-read does not abort the read.
- Transmit FIFO:
  - Circular buffer with TX_AW-bit pointers that wrap modulo 2^TX_AW, plus a TX_AW+1-bit count.
  - Push when not full: stored.
  - Push when full with no pop on that edge: byte dropped, tx_ovf<=1 (cleared only by reset).
  - Push and pop on the same edge: both succeed, count unchanged, including when full.
  - tx_full and tx_empty are registered from the next-count value and are exact on the cycle after a push or pop.
- _ft_txe rising during WR_SETUP/WR_LOW: the transaction completes anyway. The FT chip guarantees room for one byte once TXE was seen low.

Test Plan:
- Reset 5 cycles, then check all outputs -> _ft_rd=1, _ft_wr=1, ft_data_oe=0, tx_empty=1, tx_full=0, tx_ovf=0, rx_valid=0.
- Single read: rx_ready=1, _ft_rxf falls before edge 1, ft_data_in=8'hA0 ->
  - _ft_rd low after edge 3 for exactly 3 cycles;
  - rx_valid=1 for exactly one cycle after edge 6 with rx_byte=8'hA0;
  - next _ft_rd no earlier than edge 9.
- Back-to-back stream: _ft_rxf held low, bytes FE,ED,BE,EF applied per strobe -> four rx_valid pulses in order FE,ED,BE,EF, each separated by ≥6 cycles.
- Write: push 8'h5A with _ft_txe=0 ->
  - ft_data_oe=1 with ft_data_out=5A one cycle before _ft_wr falls;
  - _ft_wr low for 2 cycles;
  - oe drops one cycle after _ft_wr rises;
  - tx_empty returns to 1.
- Arbitration and overflow: with _ft_txe=1, push 17 bytes -> tx_full=1 after the 16th push, tx_ovf=1 after the 17th. Then release _ft_txe with _ft_rxf low -> grants alternate READ, WRITE, READ, ... and exactly 16 bytes are written, in order.
- Reset mid-read: assert _reset during RD_LOW -> _ft_rd=1 on the next edge, no rx_valid, state returns to IDLE, FIFO empty.
